// File: rtl/ahmes_pkg.sv
// ahmes_pkg: shared opcodes, ALU codes, controller states and flag indices for the Ahmes CPU
package ahmes_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_SUB = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JN  = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;
    localparam logic [3:0] OP_JB  = 4'hC;
    localparam logic [3:0] OP_ILL = 4'hD;
    localparam logic [3:0] OP_SHF = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [3:0] ALU_NONE = 4'h0;
    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_AND  = 4'h4;
    localparam logic [3:0] ALU_NOT  = 4'h5;
    localparam logic [3:0] ALU_ROL  = 4'h7;
    localparam logic [3:0] ALU_ROR  = 4'h8;
    localparam logic [3:0] ALU_SHL  = 4'h9;
    localparam logic [3:0] ALU_SHR  = 4'hA;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_OPADDR, S_OPDATA, S_EXEC, S_STORE, S_HALT
    } state_t;

    localparam int F_N = 4;
    localparam int F_Z = 3;
    localparam int F_C = 2;
    localparam int F_V = 1;
    localparam int F_B = 0;

    // Shift group picks its ALU code from the two low opcode bits
    function automatic logic [3:0] alu_sel(input logic [3:0] op, input logic [1:0] sh);
        return op == OP_ADD ? ALU_ADD :
               op == OP_SUB ? ALU_SUB :
               op == OP_OR  ? ALU_OR  :
               op == OP_AND ? ALU_AND :
               op == OP_NOT ? ALU_NOT :
               op == OP_SHF ? (sh[1] ? (sh[0] ? ALU_ROL : ALU_ROR) : (sh[0] ? ALU_SHL : ALU_SHR)) :
               ALU_NONE;
    endfunction

endpackage

// File: rtl/ahmes_cond_eval.sv
// ahmes_cond_eval: decides whether a conditional jump is taken
// ri    : instruction bits [7:2] (opcode nibble plus condition select)
// flags : {N,Z,C,V,B}
// taken : 1 when the jump condition holds
module ahmes_cond_eval
    import ahmes_pkg::*;
(
    input  logic [7:2] ri,
    input  logic [4:0] flags,
    output logic       taken
);

    logic flag;

    // Opcode 1001 tests N, or V when ri[3] is set; ri[2] inverts the sense
    assign flag = ri[7:4] == OP_JN ? (ri[3] ? flags[F_V] : flags[F_N]) :
                  ri[7:4] == OP_JZ ? flags[F_Z] :
                  ri[7:4] == OP_JC ? flags[F_C] :
                  flags[F_B];
    assign taken = flag ^ ri[2];

endmodule

// File: rtl/ahmes_control.sv
// ahmes_control: multicycle fetch/decode/execute controller of the 8-bit Ahmes CPU
// clk, rst          : clock and synchronous active-high reset
// mem_req/we/addr/wdata, mem_rdata, mem_ack : registered req/ack memory port
// alu_op/a/b/cin    : drive the external combinational ALU
// alu_result, alu_n/z/c/v, alu_borrow : ALU result and flags (alu_borrow is the B flag,
//                     named apart from the alu_b operand output)
// pc, ac, flags     : architectural state, flags = {N,Z,C,V,B}
// halted            : HLT executed
module ahmes_control
    import ahmes_pkg::*;
#(
    parameter logic [7:0] RESET_PC        = 8'h00,
    parameter bit         HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic [3:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_cin,
    input  logic [7:0] alu_result,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       alu_borrow,
    input  logic       alu_v,
    output logic [7:0] pc,
    output logic [7:0] ac,
    output logic [4:0] flags,
    output logic       halted
);

    state_t     state, state_d;
    logic [7:0] ri, ri_d, ea, ea_d, opb, opb_d, pc_d, ac_d;
    logic [4:0] flags_d;
    logic [3:0] op;
    logic       taken, done, is_jump;

    assign op      = ri[7:4];
    assign done    = mem_req & mem_ack;
    assign is_jump = op inside {OP_JMP, OP_JN, OP_JZ, OP_JC, OP_JB};
    assign halted  = state == S_HALT;
    assign alu_op  = state == S_EXEC ? alu_sel(op, ri[1:0]) : ALU_NONE;
    assign alu_a   = ac;
    assign alu_b   = opb;
    assign alu_cin = flags[F_C];

    ahmes_cond_eval u_cond (
        .ri    (ri[7:2]),
        .flags (flags),
        .taken (taken)
    );

    always_comb begin
        state_d = state;
        pc_d    = pc;
        ac_d    = ac;
        ri_d    = ri;
        ea_d    = ea;
        opb_d   = opb;
        flags_d = flags;
        case (state)
            S_FETCH: if (done) begin
                ri_d    = mem_rdata;
                pc_d    = pc + 8'd1;
                state_d = S_DECODE;
            end
            S_DECODE: case (op)
                OP_NOP:                    state_d = S_FETCH;
                OP_HLT:                    state_d = S_HALT;
                OP_NOT, OP_SHF:            state_d = S_EXEC;
                OP_ILL:                    state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                OP_JN, OP_JZ, OP_JC, OP_JB: begin
                    // A jump not taken skips its operand byte without reading it
                    pc_d    = taken ? pc : pc + 8'd1;
                    state_d = taken ? S_OPADDR : S_FETCH;
                end
                default:                   state_d = S_OPADDR;
            endcase
            S_OPADDR: if (done) begin
                ea_d    = mem_rdata;
                pc_d    = is_jump ? mem_rdata : pc + 8'd1;
                state_d = is_jump ? S_FETCH : op == OP_STA ? S_STORE : S_OPDATA;
            end
            S_OPDATA: if (done) begin
                opb_d   = mem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                ac_d         = op == OP_LDA ? opb : alu_result;
                flags_d[F_N] = op == OP_LDA ? opb[7] : alu_n;
                flags_d[F_Z] = op == OP_LDA ? opb == 8'h00 : alu_z;
                flags_d[F_C] = op == OP_ADD || op == OP_SHF ? alu_c : flags[F_C];
                flags_d[F_V] = op == OP_ADD || op == OP_SUB ? alu_v : flags[F_V];
                flags_d[F_B] = op == OP_SUB ? alu_borrow : flags[F_B];
                state_d      = S_FETCH;
            end
            S_STORE: if (done) state_d = S_FETCH;
            default: ;
        endcase
    end

    // Memory outputs are registered from the next state so a request is already
    // up in the first cycle of each memory state and stays still while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            ac        <= 8'h00;
            ri        <= 8'h00;
            ea        <= 8'h00;
            opb       <= 8'h00;
            flags     <= 5'b01000;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= RESET_PC;
            mem_wdata <= 8'h00;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            ac        <= ac_d;
            ri        <= ri_d;
            ea        <= ea_d;
            opb       <= opb_d;
            flags     <= flags_d;
            mem_req   <= state_d inside {S_FETCH, S_OPADDR, S_OPDATA, S_STORE};
            mem_we    <= state_d == S_STORE;
            mem_addr  <= state_d inside {S_OPDATA, S_STORE} ? ea_d : pc_d;
            mem_wdata <= ac_d;
        end
    end

endmodule

// File: doc/ahmes_control.md
Name: ahmes_control

Overview:
- Multicycle fetch/decode/execute controller for the 8-bit Ahmes CPU.
- Owns the architectural registers: PC, AC, RI, and flags N Z C V B.
- Sequences the shared memory port with a req/ack handshake.
- Drives the combinational ALU (operacao/operA/operB/Cin) and latches its result and flags.
- Sits between the memory model and the ALU; the top-level CPU is this block plus the ALU plus memory.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset
HALT_ON_ILLEGAL, 0, 1 = undefined opcode (1101) halts; 0 = treated as NOP

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
mem_req  out  1  memory transaction request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  8  transaction address
mem_wdata  out  8  write data (AC)
mem_rdata  in  8  read data, valid in the mem_ack cycle
mem_ack  in  1  transaction completes at the clock edge where mem_req&mem_ack
alu_op  out  4  ALU opcode
alu_a  out  8  ALU operand A (AC)
alu_b  out  8  ALU operand B (fetched operand)
alu_cin  out  1  ALU carry-in (C flag)
alu_result  in  8  ALU result
alu_n, alu_z, alu_c, alu_b, alu_v  in  1 each  ALU flags
pc, ac  out  8 each  architectural state (debug)
flags  out  5  {N,Z,C,V,B}
halted  out  1  HLT executed

Behaviour:
- Reset (clk edge with rst=1) sets: pc=RESET_PC, ac=0, RI=0, flags=5'b01000 (Z=1), halted=0, mem_req=0, mem_we=0, state=FETCH. Reset wins over everything, including an in-flight transaction; mem_req falls in the following cycle.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered.
  - They are held stable until the completing edge; mem_req deasserts after that edge.
  - A combinational ack (same cycle mem_req rises) is legal. An unbounded stall is legal.
- States:
  - FETCH: read [pc]. On ack: RI<=rdata, pc<=pc+1 → DECODE.
  - DECODE: classify RI[7:4].
    - NOP (0000): → FETCH.
    - HLT (1111): → HALT.
    - NOT (0110): → EXEC (no operand).
    - Shift/rotate (1110): → EXEC (no operand).
    - STA, LDA, ADD, OR, AND, SUB (0001–0101, 0111): → OPADDR.
    - JMP (1000): → OPADDR.
    - Conditional jump (1001–1100):
      - Condition per RI[3:2]: JN/JP (1001 x0/x1 on RI[2]), JV/JNV (1001 RI[3]=1), JZ/JNZ (1010), JC/JNC (1011), JB/JNB (1100).
      - Taken → OPADDR.
      - Not taken: pc<=pc+1 with no memory access → FETCH.
  - OPADDR: read [pc]. On ack: pc<=pc+1 and operand address EA<=rdata.
    - JMP or taken jump: pc<=rdata → FETCH.
    - STA → STORE.
    - Otherwise → OPDATA.
  - OPDATA: read [EA]. On ack: operand register OPB<=rdata → EXEC.
  - EXEC: one cycle. alu_a=ac, alu_b=OPB, alu_cin=C. Latch results:
    - ADD: alu_op 0001; ac<=result; update N,Z,C,V.
    - SUB: alu_op 0010; ac<=result; update N,Z,V,B; C unchanged.
    - OR 0011 / AND 0100 / NOT 0101: ac<=result; update N,Z.
    - SHR→1010, SHL→1001, ROR→1000, ROL→0111 (selected by RI[1:0]=00/01/10/11): ac<=result; update N,Z,C.
    - LDA: ac<=OPB; N=OPB[7], Z=(OPB==0); no ALU use.
    - All paths → FETCH.
  - STORE: write ac to [EA]. On ack → FETCH.
  - HALT: no memory activity, halted=1. Exit only via rst.
- Outside EXEC, alu_op=4'b0000. Flags not listed for an instruction are unchanged.
- PC and EA wrap modulo 256; incrementing 8'hFF gives 8'h00.
- Undefined opcode (1101): NOP, or HALT when HALT_ON_ILLEGAL=1.
- Cycle counts with zero-wait ack:
  - NOP: 2
  - Jump not taken: 2
  - NOT / shift: 3
  - JMP / jump taken: 3
  - STA: 4
  - LDA / ALU with memory operand: 5

Decomposition:
- Package ahmes_pkg:
  - Instruction opcode constants (upper nibble).
  - ALU opcode constants (ADIC..DAD, 0001–1010).
  - Controller state enum.
  - Flag bit indices.
- One natural sub-module: ahmes_cond_eval (combinational jump-condition evaluator, RI + flags → taken). Everything else stays inline.

Test Plan:
- Reset and idle:
  - Stimulus: rst held 2 cycles, then released with mem[0]=8'hF0.
  - Required: pc=0, ac=0, flags=01000 during reset; after release, HLT is fetched, halted=1 with pc=1, then no further mem_req.
- Overflowing add:
  - Stimulus: program LDA 80h; ADD 81h; HLT with mem[80h]=7Fh, mem[81h]=01h.
  - Required: ac=80h, N=1, V=1, Z=0, C=0, pc=05h, halted=1.
- Borrow on subtract:
  - Stimulus: program LDA 80h; SUB 81h with mem[80h]=00h, mem[81h]=01h.
  - Required: ac=FFh, N=1, B=1, C unchanged.
- Store and conditional jumps:
  - Stimulus: STA 90h after ac=FFh; then JZ 20h; then JN 20h.
  - Required: exactly one write of FFh to 90h; JZ not taken in 2 cycles with pc+=2; JN taken with pc=20h.
- Rotate through carry:
  - Stimulus: ac=81h, C=1, execute ROL.
  - Required: alu_op=0111, alu_cin=1, ac=03h, C=1.
- Stalls and reset mid-transaction:
  - Stimulus: hold mem_ack low 3 cycles during OPDATA.
  - Required: mem_req, mem_addr, mem_we stable throughout; asserting rst mid-wait gives mem_req=0 next cycle, pc=RESET_PC, and a fresh FETCH follows.
